// File: rtl/serial_crc_pkg.sv
// Constants and FSM state type shared by the serial CRC checker and the
// upstream serial CRC generator.
package serial_crc_pkg;

  localparam int unsigned DATA_W    = 6;
  localparam int unsigned CRC_W     = 5;
  localparam int unsigned FRAME_LEN = DATA_W + CRC_W;
  // x^5 + x^2 + 1; the x^5 term is implicit in the shift-out
  localparam logic [CRC_W-1:0] POLY = 5'b00101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RECV = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/crc_lfsr_step.sv
// One-bit serial CRC absorb step: shift the bit in and fold the generator
// back in whenever the register's MSB falls out.
module crc_lfsr_step #(
  parameter int unsigned      CRC_W = 5,
  parameter logic [CRC_W-1:0] POLY  = 5'b00101
) (
  input  logic [CRC_W-1:0] crc_i,
  input  logic             bit_i,
  output logic [CRC_W-1:0] crc_o
);

  logic fb;

  always_comb begin
    fb    = crc_i[CRC_W-1];
    crc_o = {crc_i[CRC_W-2:0], bit_i} ^ (fb ? POLY : '0);
  end

endmodule

// File: rtl/serial_crc_check.sv
// Serial CRC frame checker: collects DATA_W+CRC_W bits per sof-framed
// codeword and reports the payload and the remainder of the whole codeword.
module serial_crc_check
  import serial_crc_pkg::*;
#(
  parameter int unsigned      DATA_W = serial_crc_pkg::DATA_W,
  parameter int unsigned      CRC_W  = serial_crc_pkg::CRC_W,
  parameter logic [CRC_W-1:0] POLY   = serial_crc_pkg::POLY
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sof,
  input  logic              bit_valid,
  input  logic              bit_in,
  output logic              busy,
  output logic              rx_done,
  output logic [DATA_W-1:0] data_rx,
  output logic [CRC_W-1:0]  syndrome,
  output logic              crc_ok
);

  localparam int unsigned FrameLen = DATA_W + CRC_W;
  localparam int unsigned CntW     = $clog2(FrameLen + 1);

  state_e            state_q, state_d;
  logic [CRC_W-1:0]  lfsr_q, lfsr_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [DATA_W-1:0] data_rx_q;
  logic [CRC_W-1:0]  syndrome_q;
  logic              crc_ok_q;

  logic              start;
  logic              load;
  logic [CRC_W-1:0]  step_in;
  logic [CRC_W-1:0]  step_out;

  // sof restarts from a cleared LFSR in every state, so one step instance
  // serves both the first bit of a frame and every later bit.
  assign start   = bit_valid && sof;
  assign step_in = start ? '0 : lfsr_q;

  crc_lfsr_step #(
    .CRC_W (CRC_W),
    .POLY  (POLY)
  ) u_step (
    .crc_i (step_in),
    .bit_i (bit_in),
    .crc_o (step_out)
  );

  always_comb begin
    state_d = state_q;
    lfsr_d  = lfsr_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    load    = 1'b0;
    if (start) begin
      lfsr_d  = step_out;
      cnt_d   = CntW'(1);
      data_d  = DATA_W'(bit_in);
      state_d = RECV;
    end else if (state_q == RECV && bit_valid) begin
      lfsr_d = step_out;
      cnt_d  = cnt_q + CntW'(1);
      if (cnt_q < CntW'(DATA_W)) begin
        data_d = {data_q[DATA_W-2:0], bit_in};
      end
      if (cnt_q == CntW'(FrameLen - 1)) begin
        state_d = DONE;
        load    = 1'b1;
      end
    end else if (state_q == DONE) begin
      state_d = IDLE;
    end
  end

  // Results are loaded on the edge entering DONE so they are already valid
  // while rx_done is high.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      lfsr_q     <= '0;
      cnt_q      <= '0;
      data_q     <= '0;
      data_rx_q  <= '0;
      syndrome_q <= '0;
      crc_ok_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      if (load) begin
        data_rx_q  <= data_q;
        syndrome_q <= step_out;
        crc_ok_q   <= (step_out == '0);
      end
    end
  end

  assign busy     = (state_q != IDLE);
  assign rx_done  = (state_q == DONE);
  assign data_rx  = data_rx_q;
  assign syndrome = syndrome_q;
  assign crc_ok   = crc_ok_q;

endmodule

// File: tb/tb_serial_crc_check.sv
// Directed bench for serial_crc_check: good/bad frames, stalls, abort,
// mid-frame reset and back-to-back frames.
module tb_serial_crc_check;

  logic       clk = 1'b0;
  logic       reset;
  logic       sof;
  logic       bit_valid;
  logic       bit_in;
  logic       busy;
  logic       rx_done;
  logic [5:0] data_rx;
  logic [4:0] syndrome;
  logic       crc_ok;

  int checks   = 0;
  int failures = 0;

  int         done_cnt = 0;
  logic [5:0] done_data [16];
  logic [4:0] done_syn  [16];
  logic       done_ok   [16];
  time        done_time [16];

  localparam logic [10:0] GOOD = 11'b101011_10011;
  localparam logic [10:0] BAD  = 11'b101011_10010;
  localparam logic [10:0] ONES = 11'b111111_11111;
  localparam logic [10:0] ZERO = 11'b000000_00000;

  serial_crc_check dut (
    .clk       (clk),
    .reset     (reset),
    .sof       (sof),
    .bit_valid (bit_valid),
    .bit_in    (bit_in),
    .busy      (busy),
    .rx_done   (rx_done),
    .data_rx   (data_rx),
    .syndrome  (syndrome),
    .crc_ok    (crc_ok)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rx_done) begin
      if (done_cnt < 16) begin
        done_data[done_cnt] = data_rx;
        done_syn[done_cnt]  = syndrome;
        done_ok[done_cnt]   = crc_ok;
        done_time[done_cnt] = $time;
      end
      done_cnt = done_cnt + 1;
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      bit_valid = 1'b0;
      sof       = 1'b0;
      bit_in    = 1'b0;
    end
  endtask

  // Sends bits f[10], f[9], ... (n of them); a one-cycle stall with sof high
  // but bit_valid low follows bit number stall_a / stall_b (1-based).
  task automatic send_bits(input logic [10:0] f, input int n, input bit first_sof,
                           input int stall_a, input int stall_b, output time t0);
    t0 = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      sof       = first_sof && (i == 0);
      bit_valid = 1'b1;
      bit_in    = f[10-i];
      if (i == 0) t0 = $time;
      if (i + 1 == stall_a || i + 1 == stall_b) begin
        @(negedge clk);
        bit_valid = 1'b0;
        sof       = 1'b1;
        bit_in    = 1'b1;
      end
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; sof = 1'b1; bit_valid = 1'b1; bit_in = 1'b1;
    repeat (3) @(negedge clk);
    #2;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (rx_done !== 1'b0) begin failures++; $display("FAIL reset_rx_done got=%b exp=0", rx_done); end
    checks++; if (data_rx !== 6'b0) begin failures++; $display("FAIL reset_data got=%b exp=000000", data_rx); end
    checks++; if (syndrome !== 5'b0) begin failures++; $display("FAIL reset_syn got=%b exp=00000", syndrome); end
    checks++; if (crc_ok !== 1'b0) begin failures++; $display("FAIL reset_crc_ok got=%b exp=0", crc_ok); end
    @(negedge clk);
    reset = 1'b0; sof = 1'b0; bit_valid = 1'b0; bit_in = 1'b0;
    idle(2);
  endtask

  task automatic test_good_frame;
    time t0;
    int  c0 = done_cnt;
    send_bits(GOOD, 11, 1'b1, 0, 0, t0);
    #2;
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL good_busy_recv got=%b exp=1", busy); end
    idle(1); #2;
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL good_busy_done got=%b exp=1", busy); end
    idle(3); #2;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL good_busy_idle got=%b exp=0", busy); end
    checks++; if (done_cnt !== c0 + 1) begin failures++; $display("FAIL good_pulses got=%0d exp=%0d", done_cnt - c0, 1); end
    if (done_cnt > c0 && c0 < 16) begin
      checks++; if (done_time[c0] - t0 !== 110) begin failures++; $display("FAIL good_latency got=%0t exp=110", done_time[c0] - t0); end
      checks++; if (done_data[c0] !== 6'b101011) begin failures++; $display("FAIL good_data got=%b exp=101011", done_data[c0]); end
      checks++; if (done_syn[c0] !== 5'b00000) begin failures++; $display("FAIL good_syn got=%b exp=00000", done_syn[c0]); end
      checks++; if (done_ok[c0] !== 1'b1) begin failures++; $display("FAIL good_crc_ok got=%b exp=1", done_ok[c0]); end
    end
    checks++; if (crc_ok !== 1'b1 || data_rx !== 6'b101011) begin failures++; $display("FAIL good_hold got=%b/%b exp=1/101011", crc_ok, data_rx); end
  endtask

  task automatic test_stalls;
    time t0;
    int  c0 = done_cnt;
    send_bits(GOOD, 11, 1'b1, 3, 7, t0);
    idle(4); #2;
    checks++; if (done_cnt !== c0 + 1) begin failures++; $display("FAIL stall_pulses got=%0d exp=%0d", done_cnt - c0, 1); end
    if (done_cnt > c0 && c0 < 16) begin
      checks++; if (done_time[c0] - t0 !== 130) begin failures++; $display("FAIL stall_latency got=%0t exp=130", done_time[c0] - t0); end
      checks++; if (done_data[c0] !== 6'b101011 || done_syn[c0] !== 5'b0 || done_ok[c0] !== 1'b1) begin
        failures++; $display("FAIL stall_result got=%b/%b/%b exp=101011/00000/1", done_data[c0], done_syn[c0], done_ok[c0]);
      end
    end
  endtask

  task automatic test_bit_error;
    time t0;
    int  c0 = done_cnt;
    send_bits(BAD, 11, 1'b1, 0, 0, t0);
    idle(4); #2;
    checks++; if (done_cnt !== c0 + 1) begin failures++; $display("FAIL err_pulses got=%0d exp=%0d", done_cnt - c0, 1); end
    checks++; if (syndrome !== 5'b00001) begin failures++; $display("FAIL err_syn got=%b exp=00001", syndrome); end
    checks++; if (crc_ok !== 1'b0) begin failures++; $display("FAIL err_crc_ok got=%b exp=0", crc_ok); end
    checks++; if (data_rx !== 6'b101011) begin failures++; $display("FAIL err_data got=%b exp=101011", data_rx); end
  endtask

  task automatic test_abort;
    time t0, t1;
    int  c0 = done_cnt;
    send_bits(ONES, 5, 1'b1, 0, 0, t0);
    send_bits(GOOD, 11, 1'b1, 0, 0, t1);
    idle(4); #2;
    checks++; if (done_cnt !== c0 + 1) begin failures++; $display("FAIL abort_pulses got=%0d exp=%0d", done_cnt - c0, 1); end
    if (done_cnt > c0 && c0 < 16) begin
      checks++; if (done_time[c0] - t1 !== 110) begin failures++; $display("FAIL abort_latency got=%0t exp=110", done_time[c0] - t1); end
      checks++; if (done_ok[c0] !== 1'b1 || done_data[c0] !== 6'b101011) begin
        failures++; $display("FAIL abort_result got=%b/%b exp=1/101011", done_ok[c0], done_data[c0]);
      end
    end
  endtask

  task automatic test_reset_mid;
    time t0;
    int  c0 = done_cnt;
    send_bits(GOOD, 6, 1'b1, 0, 0, t0);
    @(negedge clk);
    reset = 1'b1; sof = 1'b1; bit_valid = 1'b1; bit_in = 1'b1;
    @(negedge clk);
    reset = 1'b0; sof = 1'b0; bit_valid = 1'b0; bit_in = 1'b0;
    send_bits(GOOD << 6, 5, 1'b0, 0, 0, t0);
    idle(4); #2;
    checks++; if (done_cnt !== c0) begin failures++; $display("FAIL rstmid_pulses got=%0d exp=0", done_cnt - c0); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rstmid_busy got=%b exp=0", busy); end
    checks++; if (data_rx !== 6'b0 || syndrome !== 5'b0 || crc_ok !== 1'b0) begin
      failures++; $display("FAIL rstmid_outputs got=%b/%b/%b exp=000000/00000/0", data_rx, syndrome, crc_ok);
    end
  endtask

  task automatic test_back_to_back;
    time t0, t1;
    int  c0 = done_cnt;
    send_bits(GOOD, 11, 1'b1, 0, 0, t0);
    send_bits(ZERO, 11, 1'b1, 0, 0, t1);
    idle(4); #2;
    checks++; if (done_cnt !== c0 + 2) begin failures++; $display("FAIL b2b_pulses got=%0d exp=2", done_cnt - c0); end
    checks++; if (t1 - t0 !== 110) begin failures++; $display("FAIL b2b_sof_in_done got=%0t exp=110", t1 - t0); end
    if (done_cnt >= c0 + 2 && c0 + 1 < 16) begin
      checks++; if (done_ok[c0] !== 1'b1 || done_data[c0] !== 6'b101011) begin
        failures++; $display("FAIL b2b_first got=%b/%b exp=1/101011", done_ok[c0], done_data[c0]);
      end
      checks++; if (done_ok[c0+1] !== 1'b1 || done_data[c0+1] !== 6'b000000 || done_syn[c0+1] !== 5'b0) begin
        failures++; $display("FAIL b2b_second got=%b/%b/%b exp=1/000000/00000", done_ok[c0+1], done_data[c0+1], done_syn[c0+1]);
      end
      checks++; if (done_time[c0+1] - t1 !== 110) begin failures++; $display("FAIL b2b_latency got=%0t exp=110", done_time[c0+1] - t1); end
    end
  endtask

  initial begin
    test_reset;
    test_good_frame;
    test_stalls;
    test_bit_error;
    test_abort;
    test_reset_mid;
    test_back_to_back;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/serial_crc_check.md
SERIAL_CRC_CHECK -- requirements
Module: serial_crc_check

Interface
REQ-001 Parameter DATA_W, default 6, message bits per frame.
REQ-002 Parameter CRC_W, default 5, check bits per frame; frame length FRAME_LEN = DATA_W + CRC_W = 11.
REQ-003 Parameter POLY, default 5'b00101, generator x^5+x^2+1 with implicit x^5 term.
REQ-004 clk  input  1  the block's one clock; all logic is on the rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 sof  input  1  start of frame; qualifies the first bit, sampled only when bit_valid=1.
REQ-007 bit_valid  input  1  bit_in is valid this cycle.
REQ-008 bit_in  input  1  serial codeword bit, MSB of data first, CRC MSB last-but-four.
REQ-009 busy  output  1  high while a frame is being received.
REQ-010 rx_done  output  1  one-cycle pulse when a frame completes.
REQ-011 data_rx  output  DATA_W  first DATA_W bits of the last completed frame, first bit in MSB.
REQ-012 syndrome  output  CRC_W  remainder of the last completed frame.
REQ-013 crc_ok  output  1  high when syndrome==0; held until the next rx_done.

Function
REQ-014 The FSM SHALL have states IDLE, RECV and DONE.
REQ-015 IDLE: bit_valid=1 with sof=1 SHALL clear the LFSR, absorb that bit, set bit count=1 and move to RECV; bits without sof SHALL be ignored.
REQ-016 RECV: each bit_valid=1 cycle SHALL absorb one bit, and bit_valid=0 SHALL stall with no state change.
REQ-017 Absorb rule: fb=r[CRC_W-1]; r <= {r[CRC_W-2:0], bit_in} XOR (fb ? POLY : 0).
REQ-018 The first DATA_W absorbed bits SHALL also shift into a data register, MSB first.
REQ-019 When the FRAME_LEN-th bit is absorbed, the FSM SHALL move to DONE.
REQ-020 DONE: for exactly one cycle the FSM SHALL assert rx_done, update data_rx, syndrome and crc_ok, then return to IDLE.
REQ-021 Latency: rx_done SHALL assert in the cycle after the edge that absorbed the last bit.
REQ-022 sof=1 with bit_valid=1 in RECV SHALL abort the current frame without rx_done and restart as in REQ-015.
REQ-023 A bit presented in DONE SHALL be treated as in IDLE, so back-to-back frames are accepted with sof.
REQ-024 busy SHALL be 1 in RECV and DONE, and 0 in IDLE.
REQ-025 The bit counter SHALL be ceil(log2(FRAME_LEN+1)) bits wide and SHALL never wrap within a frame.
REQ-026 data_rx, syndrome and crc_ok SHALL change only in DONE or under reset.

Reset
REQ-027 reset=1 at a clock edge SHALL force IDLE and set the LFSR, counter, data register, data_rx and syndrome to 0, busy=0, rx_done=0 and crc_ok=0.
REQ-028 Reset SHALL win over any simultaneous sof or bit_valid, and a frame in progress SHALL be discarded with no rx_done.

Structure
REQ-029 Shared package serial_crc_pkg SHALL hold CRC_W, DATA_W, FRAME_LEN and POLY, shared with the upstream serial CRC generator.
REQ-030 The FSM state enum SHALL reside in serial_crc_pkg.
REQ-031 One sub-module, crc_lfsr_step, SHALL be the combinational absorb function of REQ-017, reused by the generator.

Verification
REQ-032 Good frame: after reset, send sof plus 101011_10011 over 11 consecutive cycles -> rx_done in cycle 12 with data_rx=101011, syndrome=00000 and crc_ok=1.
REQ-033 Single-bit error: send 101011_10010 -> syndrome=00001 and crc_ok=0, with data_rx=101011.
REQ-034 Stalls: send the REQ-032 frame with bit_valid=0 inserted after bits 3 and 7 -> same result, and rx_done 2 cycles later than in REQ-032.
REQ-035 Abort: send 5 bits, then sof plus the full REQ-032 frame -> exactly one rx_done, with crc_ok=1.
REQ-036 Reset mid-frame: assert reset after bit 6, then send bits 7-11 without sof -> no rx_done, busy=0 and all outputs 0.
REQ-037 Back-to-back: send the REQ-032 frame, then all-zero 00000000000 with sof in the DONE cycle -> two rx_done pulses, both with crc_ok=1, and the second with data_rx=000000.
